// File: rtl/instr_fetch_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue_if
// Description : Fetch-side and decode-side signals of the instruction fetch
//               queue, grouped in one bundle.
//               Fetch side : in_valid1/2, in_instr1/2, in_addr, in_ready
//               Decode side: out_valid1/2, out_instr1/2, out_addr1/2, deq_cnt
//               The "slave" modport is used by the queue. The "master"
//               modport is used by the fetch/decode environment that drives it.
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_queue_if #(
  parameter int IW = 32,
  parameter int AW = 32
);
  logic          in_valid1;
  logic          in_valid2;
  logic [IW-1:0] in_instr1;
  logic [IW-1:0] in_instr2;
  logic [AW-1:0] in_addr;
  logic          in_ready;

  logic          out_valid1;
  logic          out_valid2;
  logic [IW-1:0] out_instr1;
  logic [IW-1:0] out_instr2;
  logic [AW-1:0] out_addr1;
  logic [AW-1:0] out_addr2;
  logic [1:0]    deq_cnt;

  modport slave (
    input  in_valid1, in_valid2, in_instr1, in_instr2, in_addr, deq_cnt,
    output in_ready, out_valid1, out_valid2, out_instr1, out_instr2,
           out_addr1, out_addr2
  );

  modport master (
    output in_valid1, in_valid2, in_instr1, in_instr2, in_addr, deq_cnt,
    input  in_ready, out_valid1, out_valid2, out_instr1, out_instr2,
           out_addr1, out_addr2
  );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_queue
// Description : Circular instruction queue between IF and ID. It accepts up to
//               two instructions per cycle and presents the head pair to
//               decode. Decode consumes 0, 1 or 2 entries per cycle.
//               Ports: CLK, RESET (sync, active high), FREEZE (hold all
//               state), FLUSH (drop all entries), bus (fetch/decode bundle),
//               count / full / empty (occupancy status).
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_queue #(
  parameter int DEPTH     = 8,
  parameter int IW        = 32,
  parameter int AW        = 32,
  parameter int ADDR_STEP = 4
) (
  input  wire logic                     CLK,
  input  wire logic                     RESET,
  input  wire logic                     FREEZE,
  input  wire logic                     FLUSH,
  instr_fetch_queue_if.slave            bus,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          full,
  output logic                          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_valid1;
  logic          r_valid2;
  logic          r_full;
  logic          r_empty;

  logic [AW-1:0] r_mem_addr  [DEPTH];
  logic [IW-1:0] r_mem_instr [DEPTH];

  logic          w_ready;
  logic          w_enq;
  logic [1:0]    w_enq_n;
  logic [1:0]    w_deq_req;
  logic [1:0]    w_deq_n;
  logic [CW-1:0] w_count_next;
  logic [PW-1:0] w_tail_p1;
  logic [PW-1:0] w_head_p1;

  // A single-slot fetch still needs two free entries. This keeps in_ready a
  // function of the registered count only. It does not depend on in_valid2
  // or deq_cnt.
  assign w_ready = ((c_depth - r_count) >= CW'(2)) && !FREEZE && !FLUSH;
  assign w_enq   = w_ready && bus.in_valid1;

  // The power-of-two depth lets the pointers wrap naturally.
  assign w_tail_p1 = r_tail + PW'(1);
  assign w_head_p1 = r_head + PW'(1);

  always_comb begin
    w_enq_n = 2'd0;
    if (w_enq) begin
      w_enq_n = bus.in_valid2 ? 2'd2 : 2'd1;
    end

    // deq_cnt of 3 saturates to 2.
    w_deq_req = (bus.deq_cnt[1]) ? 2'd2 : {1'b0, bus.deq_cnt[0]};

    // Decode cannot consume more than is present. The count is below 2 here,
    // so its low bits hold the clamped amount.
    w_deq_n = 2'd0;
    if (!FREEZE && !FLUSH) begin
      if (CW'(w_deq_req) > r_count) begin
        w_deq_n = r_count[1:0];
      end else begin
        w_deq_n = w_deq_req;
      end
    end

    w_count_next = r_count + CW'(w_enq_n) - CW'(w_deq_n);
  end

  // Pointer/occupancy state. FREEZE already forces enq/deq to zero, so the
  // normal update path holds everything while frozen.
  always_ff @(posedge CLK) begin
    if (RESET || FLUSH) begin
      r_head   <= '0;
      r_tail   <= '0;
      r_count  <= '0;
      r_valid1 <= 1'b0;
      r_valid2 <= 1'b0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      r_head   <= r_head + PW'(w_deq_n);
      r_tail   <= r_tail + PW'(w_enq_n);
      r_count  <= w_count_next;
      r_valid1 <= (w_count_next >= CW'(1));
      r_valid2 <= (w_count_next >= CW'(2));
      r_full   <= (w_count_next == c_depth);
      r_empty  <= (w_count_next == '0);
    end
  end

  // Entry storage is not reset. A reset during a write still blocks the write.
  always_ff @(posedge CLK) begin
    if (!RESET && w_enq) begin
      r_mem_addr[r_tail]  <= bus.in_addr;
      r_mem_instr[r_tail] <= bus.in_instr1;
      if (bus.in_valid2) begin
        r_mem_addr[w_tail_p1]  <= bus.in_addr + AW'(ADDR_STEP);
        r_mem_instr[w_tail_p1] <= bus.in_instr2;
      end
    end
  end

  assign bus.in_ready   = w_ready;
  assign bus.out_valid1 = r_valid1;
  assign bus.out_valid2 = r_valid2;
  assign bus.out_addr1  = r_mem_addr[r_head];
  assign bus.out_instr1 = r_mem_instr[r_head];
  assign bus.out_addr2  = r_mem_addr[w_head_p1];
  assign bus.out_instr2 = r_mem_instr[w_head_p1];

  assign count = r_count;
  assign full  = r_full;
  assign empty = r_empty;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_queue
// Description : Self-checking bench for instr_fetch_queue. A queue holds the
//               expected entries. Each accepted fetch pushes entries, and each
//               consumed entry is popped and compared against the head outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_queue;

  localparam int DEPTH = 8;
  localparam int IW    = 32;
  localparam int AW    = 32;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] instr;
  } ent_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       FREEZE;
  logic       FLUSH;
  logic [3:0] count;
  logic       full;
  logic       empty;

  ent_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  instr_fetch_queue_if #(.IW(IW), .AW(AW)) bus ();

  instr_fetch_queue #(
    .DEPTH(DEPTH), .IW(IW), .AW(AW), .ADDR_STEP(4)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .FREEZE(FREEZE),
    .FLUSH (FLUSH),
    .bus   (bus),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // One clock cycle. Inputs are driven after the falling edge. The pre-edge
  // checks cover in_ready and the consumed entries. The post-edge checks
  // cover occupancy and the head entries.
  task automatic step(input bit v1, input bit v2, input logic [AW-1:0] addr,
                      input logic [1:0] deq, input bit frz, input bit fl,
                      input bit rst);
    logic [IW-1:0] i1;
    logic [IW-1:0] i2;
    bit            exp_ready;
    int            d;
    ent_t          e;
    i1 = $urandom;
    i2 = $urandom;
    bus.in_valid1 = v1;
    bus.in_valid2 = v2;
    bus.in_addr   = addr;
    bus.in_instr1 = i1;
    bus.in_instr2 = i2;
    bus.deq_cnt   = deq;
    FREEZE = frz;
    FLUSH  = fl;
    RESET  = rst;
    #1;
    exp_ready = (sb.size() <= DEPTH - 2) && !frz && !fl;
    check("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_ready});
    if (rst || fl) begin
      sb.delete();
    end else if (!frz) begin
      d = (deq == 2'd0) ? 0 : (deq == 2'd1) ? 1 : 2;
      if (d > sb.size()) d = sb.size();
      for (int k = 0; k < d; k++) begin
        e = sb.pop_front();
        if (k == 0) begin
          check("deq_addr1",  {32'd0, bus.out_addr1},  {32'd0, e.addr});
          check("deq_instr1", {32'd0, bus.out_instr1}, {32'd0, e.instr});
        end else begin
          check("deq_addr2",  {32'd0, bus.out_addr2},  {32'd0, e.addr});
          check("deq_instr2", {32'd0, bus.out_instr2}, {32'd0, e.instr});
        end
      end
      if (exp_ready && v1) begin
        sb.push_back('{addr: addr, instr: i1});
        if (v2) sb.push_back('{addr: addr + 32'd4, instr: i2});
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    check("count", {60'd0, count}, 64'(sb.size()));
    check("empty", {63'd0, empty}, {63'd0, (sb.size() == 0)});
    check("full",  {63'd0, full},  {63'd0, (sb.size() == DEPTH)});
    check("out_valid1", {63'd0, bus.out_valid1}, {63'd0, (sb.size() >= 1)});
    check("out_valid2", {63'd0, bus.out_valid2}, {63'd0, (sb.size() >= 2)});
    if (sb.size() >= 1) begin
      check("head_addr1",  {32'd0, bus.out_addr1},  {32'd0, sb[0].addr});
      check("head_instr1", {32'd0, bus.out_instr1}, {32'd0, sb[0].instr});
    end
    if (sb.size() >= 2) begin
      check("head_addr2",  {32'd0, bus.out_addr2},  {32'd0, sb[1].addr});
      check("head_instr2", {32'd0, bus.out_instr2}, {32'd0, sb[1].instr});
    end
  endtask

  initial begin
    RESET = 1'b1;
    FREEZE = 1'b0;
    FLUSH = 1'b0;
    bus.in_valid1 = 1'b0;
    bus.in_valid2 = 1'b0;
    bus.in_addr   = '0;
    bus.in_instr1 = '0;
    bus.in_instr2 = '0;
    bus.deq_cnt   = 2'd0;
    @(posedge CLK);
    @(posedge CLK);
    @(negedge CLK);

    // Reset state
    step(0, 0, 32'h0, 2'd0, 0, 0, 1);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_valid1", {63'd0, bus.out_valid1}, 64'd0);

    // Pair fill to full
    for (int i = 0; i < 4; i++) step(1, 1, 32'h100 + 32'(i * 8), 2'd0, 0, 0, 0);
    check("fill_count", {60'd0, count}, 64'd8);
    check("fill_full", {63'd0, full}, 64'd1);
    check("fill_addr1", {32'd0, bus.out_addr1}, 64'h100);
    check("fill_addr2", {32'd0, bus.out_addr2}, 64'h104);
    // Full queue rejects a further pair, and a lone in_valid2 is ignored
    step(1, 1, 32'h1000, 2'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 32'h2000, 2'd2, 0, 0, 0);
    step(0, 0, 32'h0, 2'd3, 0, 0, 0);

    // Wrap across index 7 -> 0
    for (int i = 0; i < 3; i++) step(1, 1, 32'h200 + 32'(i * 8), 2'd0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 32'h0, 2'd2, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 32'h240 + 32'(i * 8), (i >= 3) ? 2'd2 : 2'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 32'h0, 2'd2, 0, 0, 0);
    check("wrap_empty", {63'd0, empty}, 64'd1);

    // Mixed: count=1, deq 2 plus single enqueue
    step(1, 0, 32'h300, 2'd0, 0, 0, 0);
    step(1, 0, 32'h304, 2'd2, 0, 0, 0);
    check("mixed_count", {60'd0, count}, 64'd1);
    check("mixed_addr1", {32'd0, bus.out_addr1}, 64'h304);

    // Flush at count=6
    step(1, 1, 32'h400, 2'd0, 0, 0, 0);
    step(1, 1, 32'h408, 2'd0, 0, 0, 0);
    step(1, 0, 32'h410, 2'd0, 0, 0, 0);
    check("preflush_count", {60'd0, count}, 64'd6);
    step(1, 1, 32'h500, 2'd2, 0, 1, 0);
    check("flush_empty", {63'd0, empty}, 64'd1);
    step(1, 0, 32'h600, 2'd0, 0, 0, 0);
    check("postflush_addr1", {32'd0, bus.out_addr1}, 64'h600);

    // Freeze at count=3
    step(1, 1, 32'h700, 2'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h780, 2'd2, 1, 0, 0);
    check("freeze_count", {60'd0, count}, 64'd3);

    // Reset mid-operation at count=5
    step(1, 1, 32'h800, 2'd0, 0, 0, 0);
    step(1, 0, 32'h900, 2'd1, 0, 1, 1);
    check("midrst_count", {60'd0, count}, 64'd0);
    check("midrst_valid1", {63'd0, bus.out_valid1}, 64'd0);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           32'($urandom) & 32'hFFFF_FFFC, 2'($urandom_range(0, 3)),
           $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 63) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
